sha256_msg_sequencer: RTL

SHA256_MSG_SEQUENCER -- requirements
Module: sha256_msg_sequencer

---
 rtl/sha256_msg_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sha256_msg_sequencer.sv
// sha256_msg_sequencer: packs 32-bit message words into padded SHA-256 blocks
// and sequences them through an external compression core.
module sha256_msg_sequencer #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [1:0]   in_bytes,
    output logic         digest_valid,
    output logic [255:0] digest,
    output logic         busy,
    output logic         core_start,
    output logic [511:0] core_block,
    output logic         core_use_iv,
    output logic [255:0] core_iv,
    input  logic         core_done,
    input  logic [255:0] core_hash
);
    typedef enum logic [2:0] {FILL, PAD2, ISSUE, WAIT, RELEASE, OUT} state_t;

    state_t            state, state_nx;
    logic [0:15][31:0] blk;
    logic [3:0]        idx;
    logic [LEN_W-1:0]  cnt, cnt_nx;
    logic              first, fin, extra, extra_80;
    logic [255:0]      chain;
    logic              acc, part;
    logic [5:0]        add;
    logic [31:0]       lw;
    logic [4:0]        p;
    logic [63:0]       len_nx, len_cur;

    assign acc = in_valid && in_ready;
    assign part = in_last && in_bytes != 2'd0;
    assign add = part ? {1'b0, in_bytes, 3'b000} : 6'd32;
    assign cnt_nx = cnt + LEN_W'(add);
    assign len_nx = 64'(cnt_nx);
    assign len_cur = 64'(cnt);
    // p is the first block word left free after the message and its 0x80 marker
    assign p = {1'b0, idx} + (part ? 5'd1 : 5'd2);
    assign lw = !part ? in_data :
                in_bytes == 2'd1 ? {in_data[31:24], 24'h800000} :
                in_bytes == 2'd2 ? {in_data[31:16], 16'h8000} :
                {in_data[31:8], 8'h80};

    assign in_ready = state == FILL && !rst;
    assign busy = !(state == FILL && idx == 4'd0 && first);
    assign core_start = state == ISSUE || state == WAIT;
    assign core_use_iv = !first;
    assign core_iv = chain;
    assign core_block = blk;

    always_comb begin
        state_nx = state;
        case (state)
            FILL:    if (acc && (in_last || idx == 4'd15)) state_nx = ISSUE;
            PAD2:    state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (core_done) state_nx = RELEASE;
            RELEASE: if (!core_done) state_nx = fin ? OUT : extra ? PAD2 : FILL;
            OUT:     state_nx = FILL;
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= FILL;
            blk          <= '0;
            idx          <= 4'd0;
            cnt          <= '0;
            first        <= 1'b1;
            fin          <= 1'b0;
            extra        <= 1'b0;
            extra_80     <= 1'b0;
            chain        <= '0;
            digest       <= '0;
            digest_valid <= 1'b0;
        end else begin
            state        <= state_nx;
            digest_valid <= state == OUT;
            if (acc) begin
                cnt <= cnt_nx;
                idx <= idx + 4'd1;
                if (!in_last) begin
                    blk[idx] <= in_data;
                end else begin
                    for (int j = 0; j < 16; j++)
                        if (j == int'(idx)) blk[4'(j)] <= lw;
                        else if (j == int'(idx) + 1 && !part) blk[4'(j)] <= 32'h8000_0000;
                        else if (j >= int'(p))
                            blk[4'(j)] <= p > 5'd14 ? 32'h0 : j == 14 ? len_nx[63:32] :
                                          j == 15 ? len_nx[31:0] : 32'h0;
                    fin      <= (p <= 5'd14);
                    extra    <= (p > 5'd14);
                    extra_80 <= !part && idx == 4'd15;
                end
            end
            if (state == PAD2) begin
                for (int j = 0; j < 16; j++)
                    blk[4'(j)] <= j == 0 && extra_80 ? 32'h8000_0000 : j == 14 ? len_cur[63:32] :
                                  j == 15 ? len_cur[31:0] : 32'h0;
                fin   <= 1'b1;
                extra <= 1'b0;
            end
            if (state == WAIT && core_done) begin
                chain <= core_hash;
                first <= 1'b0;
            end
            if (state == OUT) begin
                digest <= chain;
                idx    <= 4'd0;
                cnt    <= '0;
                first  <= 1'b1;
                fin    <= 1'b0;
            end
        end
    end
endmodule
